sim_bus_responder: RTL and testbench



---
 rtl/sim_bus_pkg.sv | 13 +
 rtl/irq_delay_channel.sv | 59 +++++
 rtl/sim_bus_responder.sv | 126 ++++++++++++
 tb/tb_sim_bus_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_bus_pkg.sv
// Shared types and constants for the simulation bus responder.
package sim_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } bus_state_t;

   localparam int unsigned WORD_BYTES    = 4;
   localparam int unsigned MAX_IRQ_COUNT = 16;

endpackage

// File: rtl/irq_delay_channel.sv
// One delayed interrupt channel.
// It holds a down-counter, an armed bit and a level request latch.
module irq_delay_channel
   import sim_bus_pkg::*;
#(
   parameter int unsigned DELAY_SIZE = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  arm,
   input  logic [DELAY_SIZE-1:0] delay,
   input  logic                  ack,
   output logic                  req
);

   logic [DELAY_SIZE-1:0] count_q, count_d;
   logic                  armed_q, armed_d;
   logic                  req_q, req_d;
   logic                  fire;

   // Count down while armed, fire at zero, and let arm reload. Firing beats ack.
   always_comb begin
      fire    = armed_q && (count_q == '0);
      count_d = count_q;
      armed_d = armed_q;
      req_d   = req_q;
      if (armed_q && !fire) begin
         count_d = count_q - DELAY_SIZE'(1);
      end
      if (fire) begin
         armed_d = 1'b0;
      end
      if (arm) begin
         count_d = delay;
         armed_d = 1'b1;
      end
      if (fire) begin
         req_d = 1'b1;
      end else if (ack) begin
         req_d = 1'b0;
      end
   end

   // Channel state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         armed_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         armed_q <= armed_d;
         req_q   <= req_d;
      end
   end

   assign req = req_q;

endmodule

// File: rtl/sim_bus_responder.sv
// Simulation-side bus partner for the core. It provides word memory with
// wait states, a side-band loader and delayed interrupt channels.
module sim_bus_responder
   import sim_bus_pkg::*;
#(
   parameter int unsigned ADDRESS_SIZE   = 15,
   parameter int unsigned WAIT_STATES    = 1,
   parameter int unsigned IRQ_COUNT      = 2,
   parameter int unsigned IRQ_DELAY_SIZE = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      strobe,
   input  logic [ADDRESS_SIZE-1:0]   address,
   input  logic [31:0]               dataWrite,
   input  logic [3:0]                writeEnable,
   output logic [31:0]               dataRead,
   output logic                      ready,
   output logic                      busError,
   input  logic                      loadEnable,
   input  logic [ADDRESS_SIZE-3:0]   loadAddress,
   input  logic [31:0]               loadData,
   input  logic                      irqArm,
   input  logic [3:0]                irqChannel,
   input  logic [IRQ_DELAY_SIZE-1:0] irqDelay,
   input  logic [IRQ_COUNT-1:0]      irqAck,
   output logic [IRQ_COUNT-1:0]      interruptReq
);

   localparam int unsigned WORD_COUNT = 2 ** (ADDRESS_SIZE - 2);
   localparam int unsigned COUNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   if (IRQ_COUNT < 1 || IRQ_COUNT > MAX_IRQ_COUNT) begin : g_bad_irq_count
      $error("IRQ_COUNT out of range");
   end

   logic [31:0]             mem [WORD_COUNT];
   bus_state_t              state_q, state_d;
   logic [COUNT_W-1:0]      count_q, count_d;
   logic [31:0]             data_read_q, data_read_d;
   logic                    bus_error_q, bus_error_d;
   logic                    commit;
   logic [ADDRESS_SIZE-3:0] word_addr;

   assign word_addr = address[ADDRESS_SIZE-1:2];

   // Bus FSM. Completion (read capture, write commit, error check) happens on the edge entering DONE.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      data_read_d = data_read_q;
      bus_error_d = bus_error_q;
      commit      = 1'b0;
      case (state_q)
         IDLE: begin
            if (strobe) begin
               state_d = WAIT;
               count_d = COUNT_W'(WAIT_STATES);
            end
         end
         WAIT: begin
            if (!strobe) begin
               state_d = IDLE;
            end else if (count_q == '0) begin
               state_d     = DONE;
               commit      = 1'b1;
               data_read_d = mem[word_addr];
               if (address[1:0] != 2'b00) begin
                  bus_error_d = 1'b1;
               end
            end else begin
               count_d = count_q - COUNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         data_read_q <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         data_read_q <= data_read_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Memory writes. The bus lanes are assigned after the loader so they win on a shared word.
   always_ff @(posedge clock) begin
      if (loadEnable) begin
         mem[loadAddress] <= loadData;
      end
      if (commit) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (writeEnable[i]) begin
               mem[word_addr][8*i +: 8] <= dataWrite[8*i +: 8];
            end
         end
      end
   end

   assign dataRead = data_read_q;
   assign ready    = (state_q == DONE);
   assign busError = bus_error_q;

   for (genvar g = 0; g < IRQ_COUNT; g++) begin : g_irq
      irq_delay_channel #(
         .DELAY_SIZE(IRQ_DELAY_SIZE)
      ) u_channel (
         .clock(clock),
         .reset(reset),
         .arm  (irqArm && (irqChannel == 4'(g))),
         .delay(irqDelay),
         .ack  (irqAck[g]),
         .req  (interruptReq[g])
      );
   end

endmodule

// File: tb/tb_sim_bus_responder.sv
// Bench for sim_bus_responder: directed scenarios plus randomized bus and interrupt traffic.
module tb_sim_bus_responder;

   localparam int unsigned AW   = 15;
   localparam int unsigned WS   = 1;
   localparam int unsigned IRQN = 2;
   localparam int unsigned DW   = 16;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            strobe = 1'b0;
   logic [AW-1:0]   address = '0;
   logic [31:0]     dataWrite = '0;
   logic [3:0]      writeEnable = '0;
   logic [31:0]     dataRead;
   logic            ready;
   logic            busError;
   logic            loadEnable = 1'b0;
   logic [AW-3:0]   loadAddress = '0;
   logic [31:0]     loadData = '0;
   logic            irqArm = 1'b0;
   logic [3:0]      irqChannel = '0;
   logic [DW-1:0]   irqDelay = '0;
   logic [IRQN-1:0] irqAck = '0;
   logic [IRQN-1:0] interruptReq;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mem_m [64];

   sim_bus_responder #(
      .ADDRESS_SIZE  (AW),
      .WAIT_STATES   (WS),
      .IRQ_COUNT     (IRQN),
      .IRQ_DELAY_SIZE(DW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .strobe      (strobe),
      .address     (address),
      .dataWrite   (dataWrite),
      .writeEnable (writeEnable),
      .dataRead    (dataRead),
      .ready       (ready),
      .busError    (busError),
      .loadEnable  (loadEnable),
      .loadAddress (loadAddress),
      .loadData    (loadData),
      .irqArm      (irqArm),
      .irqChannel  (irqChannel),
      .irqDelay    (irqDelay),
      .irqAck      (irqAck),
      .interruptReq(interruptReq)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] byte_addr(input logic [5:0] w, input logic [1:0] off);
      logic [AW-1:0] a;
      a      = '0;
      a[7:2] = w;
      a[1:0] = off;
      return a;
   endfunction

   // One loader write; mirrored into the model.
   task automatic load_word(input logic [5:0] w, input logic [31:0] d);
      @(negedge clock);
      loadEnable  = 1'b1;
      loadAddress = '0;
      loadAddress[5:0] = w;
      loadData    = d;
      @(negedge clock);
      loadEnable  = 1'b0;
      mem_m[w]    = d;
   endtask

   // One bus transaction; lat = edges from the first edge after strobe up to ready, -1 on timeout.
   task automatic bus_txn(input logic [AW-1:0] addr, input logic [31:0] wd, input logic [3:0] we,
                          output logic [31:0] rd, output int lat);
      logic [5:0] w;
      w   = addr[7:2];
      lat = -1;
      rd  = '0;
      @(negedge clock);
      strobe = 1'b1; address = addr; dataWrite = wd; writeEnable = we;
      for (int e = 1; e <= 20 && lat < 0; e++) begin
         @(posedge clock); #1;
         if (ready) begin
            lat = e;
            rd  = dataRead;
         end
      end
      @(negedge clock);
      strobe = 1'b0; writeEnable = '0;
      if (lat >= 0) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
         end
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready); end
      vectors++; if (dataRead !== 32'h0) begin miscompares++; $display("FAIL reset_dataRead: got %h want 0", dataRead); end
      vectors++; if (busError !== 1'b0) begin miscompares++; $display("FAIL reset_busError: got %b want 0", busError); end
      vectors++; if (interruptReq !== '0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", interruptReq); end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) load_word(6'(i), $urandom);
   endtask

   task automatic test_loader_read();
      logic [31:0] rd; int lat;
      load_word(6'd5, 32'hDEADBEEF);
      bus_txn(15'h0014, 32'h0, 4'b0000, rd, lat);
      vectors++; if (lat !== int'(WS + 2)) begin miscompares++; $display("FAIL load_read_latency: got %0d want %0d", lat, WS + 2); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_read_data: got %h want deadbeef", rd); end
      vectors++; if (busError !== 1'b0) begin miscompares++; $display("FAIL load_read_busError: got %b want 0", busError); end
   endtask

   task automatic test_masked_write();
      logic [31:0] rd; int lat;
      load_word(6'd9, 32'hAABBCCDD);
      bus_txn(byte_addr(6'd9, 2'd0), 32'h11223344, 4'b0101, rd, lat);
      vectors++; if (rd !== 32'hAABBCCDD) begin miscompares++; $display("FAIL masked_write_preread: got %h want aabbccdd", rd); end
      bus_txn(byte_addr(6'd9, 2'd0), 32'h0, 4'b0000, rd, lat);
      vectors++; if (rd !== 32'hAA22CC44) begin miscompares++; $display("FAIL masked_write_result: got %h want aa22cc44", rd); end
   endtask

   task automatic test_abandon();
      logic [31:0] rd; int lat; logic seen;
      load_word(6'd12, 32'h12345678);
      @(negedge clock);
      strobe = 1'b1; address = byte_addr(6'd12, 2'd0); dataWrite = 32'hFFFFFFFF; writeEnable = 4'b1111;
      @(posedge clock); #1;
      seen = ready;
      @(negedge clock);
      strobe = 1'b0; writeEnable = '0;
      for (int e = 0; e < 6; e++) begin
         @(posedge clock); #1;
         seen = seen | ready;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abandon_no_ready: got %b want 0", seen); end
      bus_txn(byte_addr(6'd12, 2'd0), 32'h0, 4'b0000, rd, lat);
      vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("FAIL abandon_mem: got %h want 12345678", rd); end
   endtask

   task automatic test_back_to_back();
      int edge_no[2]; logic [31:0] rdv[2]; int n; logic [31:0] old; logic [31:0] rd; int lat;
      old = mem_m[20];
      n = 0;
      edge_no[0] = 0; edge_no[1] = 0; rdv[0] = '0; rdv[1] = '0;
      @(negedge clock);
      strobe = 1'b1; address = byte_addr(6'd20, 2'd0); dataWrite = 32'hA5A5_0001; writeEnable = 4'b1111;
      for (int e = 1; e <= 30 && n < 2; e++) begin
         @(posedge clock); #1;
         if (ready) begin
            edge_no[n] = e;
            rdv[n] = dataRead;
            n++;
            @(negedge clock);
            dataWrite = 32'h5A5A_0002;
         end
      end
      @(negedge clock);
      strobe = 1'b0; writeEnable = '0;
      vectors++; if (n !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", n); end
      vectors++; if (edge_no[1] - edge_no[0] < 2) begin miscompares++; $display("FAIL b2b_gap: got %0d want >=2", edge_no[1] - edge_no[0]); end
      vectors++; if (rdv[0] !== old) begin miscompares++; $display("FAIL b2b_first_data: got %h want %h", rdv[0], old); end
      vectors++; if (rdv[1] !== 32'hA5A5_0001) begin miscompares++; $display("FAIL b2b_second_data: got %h want a5a50001", rdv[1]); end
      mem_m[20] = 32'h5A5A_0002;
      bus_txn(byte_addr(6'd20, 2'd0), 32'h0, 4'b0000, rd, lat);
      vectors++; if (rd !== 32'h5A5A_0002) begin miscompares++; $display("FAIL b2b_final_mem: got %h want 5a5a0002", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; int lat;
      bus_txn(15'h0015, 32'h0, 4'b0000, rd, lat);
      vectors++; if (rd !== mem_m[5]) begin miscompares++; $display("FAIL misaligned_data: got %h want %h", rd, mem_m[5]); end
      vectors++; if (busError !== 1'b1) begin miscompares++; $display("FAIL misaligned_flag: got %b want 1", busError); end
      bus_txn(byte_addr(6'd6, 2'd0), 32'h0, 4'b0000, rd, lat);
      vectors++; if (busError !== 1'b1) begin miscompares++; $display("FAIL misaligned_sticky: got %b want 1", busError); end
   endtask

   task automatic test_collision();
      logic [31:0] old; logic [31:0] rd; int lat;
      load_word(6'd30, 32'hC0C0C0C0);
      old = mem_m[30];
      @(negedge clock);
      strobe = 1'b1; address = byte_addr(6'd30, 2'd0); dataWrite = 32'h11223344; writeEnable = 4'b1001;
      repeat (WS + 1) @(posedge clock);
      @(negedge clock);
      loadEnable = 1'b1; loadAddress = '0; loadAddress[5:0] = 6'd30; loadData = 32'h55667788;
      @(posedge clock); #1;
      vectors++; if (ready !== 1'b1 || dataRead !== old) begin miscompares++; $display("FAIL collision_done: got ready=%b data=%h want ready=1 data=%h", ready, dataRead, old); end
      @(negedge clock);
      loadEnable = 1'b0; strobe = 1'b0; writeEnable = '0;
      mem_m[30] = 32'h11667744;
      bus_txn(byte_addr(6'd30, 2'd0), 32'h0, 4'b0000, rd, lat);
      vectors++; if (rd !== 32'h11667744) begin miscompares++; $display("FAIL collision_merge: got %h want 11667744", rd); end
   endtask

   task automatic test_irq_directed();
      logic any;
      @(negedge clock);
      irqArm = 1'b1; irqChannel = 4'd1; irqDelay = DW'(3);
      @(posedge clock);
      @(negedge clock);
      irqArm = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clock); #1;
         vectors++;
         if (interruptReq !== ((e < 4) ? 2'b00 : 2'b10)) begin
            miscompares++; $display("FAIL irq_delay3_edge%0d: got %b want %b", e, interruptReq, (e < 4) ? 2'b00 : 2'b10);
         end
      end
      @(negedge clock); irqAck = 2'b10;
      @(posedge clock); #1;
      vectors++; if (interruptReq !== 2'b00) begin miscompares++; $display("FAIL irq_ack: got %b want 00", interruptReq); end
      @(negedge clock); irqAck = '0;
      irqArm = 1'b1; irqChannel = 4'd0; irqDelay = '0;
      @(posedge clock); #1;
      vectors++; if (interruptReq !== 2'b00) begin miscompares++; $display("FAIL irq_delay0_armedge: got %b want 00", interruptReq); end
      @(negedge clock); irqArm = 1'b0;
      @(posedge clock); #1;
      vectors++; if (interruptReq !== 2'b01) begin miscompares++; $display("FAIL irq_delay0_fire: got %b want 01", interruptReq); end
      @(negedge clock); irqAck = 2'b01;
      @(negedge clock); irqAck = '0;
      irqArm = 1'b1; irqChannel = 4'd7; irqDelay = '0;
      @(negedge clock); irqArm = 1'b0;
      any = 1'b0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clock); #1;
         any = any | (|interruptReq);
      end
      vectors++; if (any !== 1'b0) begin miscompares++; $display("FAIL irq_bad_channel: got %b want 0", any); end
   endtask

   // Reference: each channel keeps an absolute firing deadline in edges.
   task automatic test_irq_random();
      int dl[IRQN]; bit armed_m[IRQN]; logic [IRQN-1:0] req_m; int t; bit fire;
      req_m = '0; t = 0;
      for (int c = 0; c < IRQN; c++) begin dl[c] = 0; armed_m[c] = 0; end
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         irqArm     = ($urandom_range(0, 3) == 0);
         irqChannel = 4'($urandom_range(0, 3));
         irqDelay   = DW'($urandom_range(0, 12));
         for (int c = 0; c < IRQN; c++) irqAck[c] = ($urandom_range(0, 7) == 0);
         @(posedge clock);
         t++;
         for (int c = 0; c < IRQN; c++) begin
            fire = armed_m[c] && (dl[c] == t);
            if (irqArm && int'(irqChannel) == c) begin
               armed_m[c] = 1;
               dl[c] = t + int'(irqDelay) + 1;
            end else if (fire) begin
               armed_m[c] = 0;
            end
            if (fire) req_m[c] = 1'b1;
            else if (irqAck[c]) req_m[c] = 1'b0;
         end
         #1;
         vectors++;
         if (interruptReq !== req_m) begin miscompares++; $display("FAIL irq_random_cycle%0d: got %b want %b", k, interruptReq, req_m); end
      end
      @(negedge clock);
      irqArm = 1'b0; irqAck = '1;
      repeat (20) @(negedge clock);
      irqAck = '0;
   endtask

   task automatic test_bus_random();
      logic [5:0] w; logic [31:0] exp, rd, wd; logic [3:0] we; int lat;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) load_word(6'($urandom_range(0, 63)), $urandom);
         w   = 6'($urandom_range(0, 15));
         wd  = $urandom;
         we  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         exp = mem_m[w];
         bus_txn(byte_addr(w, 2'($urandom_range(0, 3))), wd, we, rd, lat);
         vectors++;
         if (lat !== int'(WS + 2) || rd !== exp) begin
            miscompares++; $display("FAIL bus_random_%0d: got lat=%0d data=%h want lat=%0d data=%h", k, lat, rd, WS + 2, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; int lat; logic any;
      load_word(6'd40, 32'h0BADF00D);
      @(negedge clock);
      strobe = 1'b1; address = byte_addr(6'd40, 2'd0); dataWrite = 32'hFFFFFFFF; writeEnable = 4'b1111;
      irqArm = 1'b1; irqChannel = 4'd0; irqDelay = DW'(10);
      @(posedge clock);
      @(negedge clock);
      irqArm = 1'b0;
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (ready !== 1'b0 || dataRead !== 32'h0 || busError !== 1'b0 || interruptReq !== '0) begin
         miscompares++; $display("FAIL reset_mid_outputs: got ready=%b data=%h err=%b irq=%b want all 0", ready, dataRead, busError, interruptReq);
      end
      @(negedge clock);
      strobe = 1'b0; writeEnable = '0;
      @(negedge clock);
      reset = 1'b0;
      any = 1'b0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clock); #1;
         any = any | (|interruptReq);
      end
      vectors++; if (any !== 1'b0) begin miscompares++; $display("FAIL reset_mid_no_irq: got %b want 0", any); end
      bus_txn(byte_addr(6'd40, 2'd0), 32'h0, 4'b0000, rd, lat);
      vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL reset_mid_mem: got %h want 0badf00d", rd); end
   endtask

   initial begin
      test_reset();
      test_loader_read();
      test_masked_write();
      test_abandon();
      test_back_to_back();
      test_misaligned();
      test_collision();
      test_irq_directed();
      test_irq_random();
      test_bus_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
